// File: rtl/multdiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: FSM state
// encodings, operation encoding and the signed-minimum helper.
package multdiv_pkg;

  // FSM state encodings (kept as plain constants for legacy tools)
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Operation encoding held in the capture register
  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  // Widest WIDTH the signed-minimum helper can describe
  localparam int MAX_WIDTH = 256;

  // Most negative two's-complement value of a given width, LSB-aligned
  function automatic logic [MAX_WIDTH-1:0] signed_min(input int width);
    logic [MAX_WIDTH-1:0] v;
    v = '0;
    v[width-1] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/multdiv_step.sv
// One combinational iteration of the shared datapath.
//   multiply: {acc,low} is the partial product, low's LSB selects whether
//             opnd (multiplicand magnitude) is added before the right shift.
//   divide:   acc is the partial remainder, low shifts the dividend out of
//             its MSB and the quotient bits into its LSB; opnd is the divisor.
module multdiv_step
  import multdiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             op,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] low,
  input  logic [WIDTH-1:0] opnd,
  output logic [WIDTH-1:0] acc_nxt,
  output logic [WIDTH-1:0] low_nxt
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // Shift-add for multiply, trial subtract / restore for divide
  always_comb begin
    sum     = {1'b0, acc} + {1'b0, opnd};
    shifted = {acc, low[WIDTH-1]};
    diff    = shifted - {1'b0, opnd};
    acc_nxt = acc;
    low_nxt = low;
    if (op == OP_MUL) begin
      if (low[0]) begin
        acc_nxt = sum[WIDTH:1];
        low_nxt = {sum[0], low[WIDTH-1:1]};
      end else begin
        acc_nxt = {1'b0, acc[WIDTH-1:1]};
        low_nxt = {acc[0], low[WIDTH-1:1]};
      end
    end else begin
      // The remainder invariant keeps a non-negative difference below 2^WIDTH,
      // so diff's top bit is a clean borrow flag.
      if (!diff[WIDTH]) begin
        acc_nxt = diff[WIDTH-1:0];
        low_nxt = {low[WIDTH-2:0], 1'b1};
      end else begin
        acc_nxt = shifted[WIDTH-1:0];
        low_nxt = {low[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/multdiv_seq.sv
// Iterative integer multiply/divide unit. Operands are reduced to
// magnitudes at capture, WIDTH iterations run through multdiv_step, and
// signs/exceptions are resolved on the cycle that enters DONE.
//
// Handshake: a start (ctrl_MULT or ctrl_DIV) is accepted unconditionally in
// any state and aborts any operation in flight; data_resultRDY is a
// one-cycle valid pulse with no backpressure, and data_result,
// data_result_hi and data_exception hold until the next completion or reset.
module multdiv_seq
  import multdiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH+1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic             ctrl_SIGNED,
  input  logic             ctrl_REM,
  output logic [WIDTH-1:0] data_result,
  output logic [WIDTH-1:0] data_result_hi,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             data_busy,
  output logic [1:0]       dbg_state
);

  localparam logic [MAX_WIDTH-1:0] MIN_FULL = signed_min(WIDTH);
  localparam logic [WIDTH-1:0]     MIN_VAL  = MIN_FULL[WIDTH-1:0];

  logic [1:0]       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             op_q, signed_q, rem_q, neg_res_q, neg_a_q;
  logic             div_zero_q, div_ovf_q;
  logic [WIDTH-1:0] acc_q, low_q, opnd_q;
  logic [WIDTH-1:0] acc_nxt, low_nxt;

  logic             start, sign_a, sign_b;
  logic [WIDTH-1:0] mag_a, mag_b;

  logic [2*WIDTH-1:0] prod_mag, prod;
  logic [WIDTH-1:0]   quo, rmd, fin_lo, fin_hi;
  logic               fin_exc, last_iter;

  multdiv_step #(.WIDTH(WIDTH)) u_step (
    .op      (op_q),
    .acc     (acc_q),
    .low     (low_q),
    .opnd    (opnd_q),
    .acc_nxt (acc_nxt),
    .low_nxt (low_nxt)
  );

  // Start decode and operand magnitudes for capture
  always_comb begin
    start  = ctrl_MULT | ctrl_DIV;
    sign_a = ctrl_SIGNED & data_operandA[WIDTH-1];
    sign_b = ctrl_SIGNED & data_operandB[WIDTH-1];
    mag_a  = sign_a ? -data_operandA : data_operandA;
    mag_b  = sign_b ? -data_operandB : data_operandB;
  end

  // Final sign fix-up and exception decode from the last iteration's output
  always_comb begin
    last_iter = (cnt_q == CNT_W'(WIDTH-1));
    prod_mag  = {acc_nxt, low_nxt};
    prod      = neg_res_q ? -prod_mag : prod_mag;
    quo       = neg_res_q ? -low_nxt : low_nxt;
    rmd       = neg_a_q ? -acc_nxt : acc_nxt;
    fin_lo    = '0;
    fin_hi    = '0;
    fin_exc   = 1'b0;
    if (op_q == OP_MUL) begin
      fin_lo  = prod[WIDTH-1:0];
      fin_hi  = prod[2*WIDTH-1:WIDTH];
      fin_exc = signed_q ? (fin_hi != {WIDTH{fin_lo[WIDTH-1]}}) : (fin_hi != '0);
    end else if (div_zero_q) begin
      fin_exc = 1'b1;
    end else begin
      fin_lo  = rem_q ? rmd : quo;
      fin_exc = div_ovf_q;
    end
  end

  // FSM, iteration counter, capture registers and result registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      op_q           <= OP_MUL;
      signed_q       <= 1'b0;
      rem_q          <= 1'b0;
      neg_res_q      <= 1'b0;
      neg_a_q        <= 1'b0;
      div_zero_q     <= 1'b0;
      div_ovf_q      <= 1'b0;
      acc_q          <= '0;
      low_q          <= '0;
      opnd_q         <= '0;
      data_result    <= '0;
      data_result_hi <= '0;
      data_exception <= 1'b0;
    end else if (start) begin
      state_q    <= ST_RUN;
      cnt_q      <= '0;
      op_q       <= ctrl_MULT ? OP_MUL : OP_DIV;
      signed_q   <= ctrl_SIGNED;
      rem_q      <= ctrl_REM;
      neg_res_q  <= sign_a ^ sign_b;
      neg_a_q    <= sign_a;
      div_zero_q <= (data_operandB == '0);
      div_ovf_q  <= ctrl_SIGNED && (data_operandA == MIN_VAL) && (data_operandB == '1);
      acc_q      <= '0;
      low_q      <= ctrl_MULT ? mag_b : mag_a;
      opnd_q     <= ctrl_MULT ? mag_a : mag_b;
    end else begin
      case (state_q)
        ST_RUN: begin
          acc_q <= acc_nxt;
          low_q <= low_nxt;
          cnt_q <= cnt_q + CNT_W'(1);
          if (last_iter) begin
            state_q        <= ST_DONE;
            data_result    <= fin_lo;
            data_result_hi <= fin_hi;
            data_exception <= fin_exc;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign data_resultRDY = (state_q == ST_DONE);
  assign data_busy      = (state_q == ST_RUN);
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_multdiv_seq.sv
// Directed bench for multdiv_seq at WIDTH=32 with hand-computed vectors.
module tb_multdiv_seq;

  localparam int W   = 32;
  localparam int LAT = W + 1;

  logic         clock;
  logic         reset;
  logic [W-1:0] data_operandA, data_operandB;
  logic         ctrl_MULT, ctrl_DIV, ctrl_SIGNED, ctrl_REM;
  logic [W-1:0] data_result, data_result_hi;
  logic         data_exception, data_resultRDY, data_busy;
  logic [1:0]   dbg_state;

  int tests_run = 0;
  int tests_failed = 0;

  multdiv_seq #(.WIDTH(W)) dut (
    .clock          (clock),
    .reset          (reset),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .ctrl_SIGNED    (ctrl_SIGNED),
    .ctrl_REM       (ctrl_REM),
    .data_result    (data_result),
    .data_result_hi (data_result_hi),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .data_busy      (data_busy),
    .dbg_state      (dbg_state)
  );

  // Clock
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive a start at the current negedge; it is sampled by the next posedge
  task automatic drive_start(input logic mul, input logic div, input logic sgn,
                             input logic rem, input logic [W-1:0] a, input logic [W-1:0] b);
    data_operandA = a;
    data_operandB = b;
    ctrl_MULT     = mul;
    ctrl_DIV      = div;
    ctrl_SIGNED   = sgn;
    ctrl_REM      = rem;
    @(negedge clock);
    ctrl_MULT = 1'b0;
    ctrl_DIV  = 1'b0;
  endtask

  task automatic start_op(input logic mul, input logic div, input logic sgn,
                          input logic rem, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clock);
    drive_start(mul, div, sgn, rem, a, b);
  endtask

  // Called at the negedge after the start edge; lat = cycle index of RDY, -1 on timeout
  task automatic wait_rdy(output int lat, output int busy_cnt);
    int n;
    n = 1;
    busy_cnt = 0;
    while (!data_resultRDY && n < 100) begin
      if (data_busy) busy_cnt++;
      @(negedge clock);
      n++;
    end
    lat = data_resultRDY ? n : -1;
  endtask

  task automatic run_op(input string tag, input logic mul, input logic sgn, input logic rem,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp_lo, input logic [W-1:0] exp_hi, input logic exp_exc);
    int lat, bc;
    start_op(mul, !mul, sgn, rem, a, b);
    wait_rdy(lat, bc);
    check({tag, "_lat"}, 64'(lat), 64'(LAT));
    check({tag, "_lo"},  64'(data_result), 64'(exp_lo));
    check({tag, "_hi"},  64'(data_result_hi), 64'(exp_hi));
    check({tag, "_exc"}, 64'(data_exception), 64'(exp_exc));
  endtask

  initial begin
    int lat, bc, seen;
    reset = 1'b1;
    data_operandA = '0; data_operandB = '0;
    ctrl_MULT = 1'b0; ctrl_DIV = 1'b0; ctrl_SIGNED = 1'b0; ctrl_REM = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    // Reset state
    check("rst_result", 64'(data_result), 64'h0);
    check("rst_hi", 64'(data_result_hi), 64'h0);
    check("rst_exc", 64'(data_exception), 64'h0);
    check("rst_rdy", 64'(data_resultRDY), 64'h0);
    check("rst_busy", 64'(data_busy), 64'h0);

    // Signed 7 x -3, with busy window and single-pulse checks
    start_op(1'b1, 1'b0, 1'b1, 1'b0, 32'd7, 32'hFFFFFFFD);
    wait_rdy(lat, bc);
    check("smul_lat", 64'(lat), 64'(LAT));
    check("smul_busy_cycles", 64'(bc), 64'(W));
    check("smul_busy_at_rdy", 64'(data_busy), 64'h0);
    check("smul_lo", 64'(data_result), 64'hFFFFFFEB);
    check("smul_hi", 64'(data_result_hi), 64'hFFFFFFFF);
    check("smul_exc", 64'(data_exception), 64'h0);
    @(negedge clock);
    check("smul_rdy_one_cycle", 64'(data_resultRDY), 64'h0);
    check("smul_hold", 64'(data_result), 64'hFFFFFFEB);

    run_op("umul_ovf", 1'b1, 1'b0, 1'b0, 32'h00010000, 32'h00010000, 32'h0, 32'h1, 1'b1);
    run_op("umul_max", 1'b1, 1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1, 32'hFFFFFFFE, 1'b1);
    run_op("smul_min_neg1", 1'b1, 1'b1, 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h0, 1'b1);
    run_op("sdiv_q", 1'b0, 1'b1, 1'b0, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'h0, 1'b0);
    run_op("sdiv_r", 1'b0, 1'b1, 1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'h0, 1'b0);
    run_op("sdiv_r_posdvd", 1'b0, 1'b1, 1'b1, 32'd7, 32'hFFFFFFFE, 32'd1, 32'h0, 1'b0);
    run_op("div_zero", 1'b0, 1'b0, 1'b0, 32'd5, 32'd0, 32'h0, 32'h0, 1'b1);
    run_op("div_zero_srem", 1'b0, 1'b1, 1'b1, 32'd5, 32'd0, 32'h0, 32'h0, 1'b1);
    run_op("sdiv_min_q", 1'b0, 1'b1, 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h0, 1'b1);
    run_op("sdiv_min_r", 1'b0, 1'b1, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h0, 1'b1);

    // Start accepted in DONE: a new unsigned divide begins on the pulse cycle
    run_op("udiv_a", 1'b0, 1'b0, 1'b0, 32'd100, 32'd9, 32'd11, 32'h0, 1'b0);
    drive_start(1'b0, 1'b1, 1'b0, 1'b1, 32'hFFFFFFFF, 32'h10);
    check("done_restart_busy", 64'(data_busy), 64'h1);
    wait_rdy(lat, bc);
    check("done_restart_lat", 64'(lat), 64'(LAT));
    check("done_restart_rem", 64'(data_result), 64'hF);

    // Abort: multiply at t, divide at t+10; only the divide completes
    start_op(1'b1, 1'b0, 1'b0, 1'b0, 32'd3, 32'd4);
    seen = 0;
    repeat (8) begin
      @(negedge clock);
      if (data_resultRDY) seen++;
    end
    start_op(1'b0, 1'b1, 1'b0, 1'b0, 32'd100, 32'd7);
    wait_rdy(lat, bc);
    check("abort_no_early_rdy", 64'(seen), 64'h0);
    check("abort_lat", 64'(lat), 64'(LAT));
    check("abort_result", 64'(data_result), 64'd14);
    check("abort_hi", 64'(data_result_hi), 64'h0);

    // Reset mid-operation at t+5: outputs cleared, no pulse afterwards
    start_op(1'b1, 1'b0, 1'b1, 1'b0, 32'd7, 32'hFFFFFFFD);
    repeat (4) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("midrst_result", 64'(data_result), 64'h0);
    check("midrst_hi", 64'(data_result_hi), 64'h0);
    check("midrst_exc", 64'(data_exception), 64'h0);
    check("midrst_busy", 64'(data_busy), 64'h0);
    check("midrst_rdy", 64'(data_resultRDY), 64'h0);
    seen = 0;
    repeat (40) begin
      @(negedge clock);
      if (data_resultRDY) seen++;
    end
    check("midrst_no_rdy", 64'(seen), 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/multdiv_seq.md
Name: multdiv_seq

Overview:
- Parametrised, iterative integer multiply/divide unit for the processor's execute stage; successor to the fixed 32-bit mult/div pair.
- Runs radix-2 shift-add multiply and restoring divide through one shared datapath.
- Adds over the previous generation:
  - configurable width;
  - signed/unsigned mode;
  - quotient/remainder select and full high-half product;
  - explicit busy flag, synchronous reset, and defined restart/abort semantics.

Parameters:
- WIDTH, 32, operand/result width in bits (>= 4).
- CNT_W, $clog2(WIDTH+1), iteration counter width (derived; not overridden).

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- data_operandA  in  WIDTH  multiplicand / dividend; sampled only on accepted start.
- data_operandB  in  WIDTH  multiplier / divisor; sampled only on accepted start.
- ctrl_MULT  in  1  single-cycle start pulse for multiply.
- ctrl_DIV  in  1  single-cycle start pulse for divide.
- ctrl_SIGNED  in  1  two's-complement operands when 1; sampled with start.
- ctrl_REM  in  1  divide returns remainder instead of quotient; sampled with start; ignored for multiply.
- data_result  out  WIDTH  low product / quotient / remainder.
- data_result_hi  out  WIDTH  high product half; 0 for divide.
- data_exception  out  1  overflow or divide-by-zero; valid when data_resultRDY is 1.
- data_resultRDY  out  1  one-cycle completion pulse.
- data_busy  out  1  high while an operation is in flight.

Behaviour:
- Reset: state IDLE; all outputs 0; counter 0.
- Reset dominates every other input in the same cycle, including mid-operation; no RDY pulse is produced for an operation killed by reset.
- States: IDLE, RUN, DONE.
- Start: ctrl_MULT or ctrl_DIV high in any state.
  - Captures operands, mode and op; counter = 0; enters RUN.
  - Start while RUN aborts the current operation and restarts with the new operands; the aborted operation produces no RDY.
  - Start in DONE is accepted; DONE still emits its pulse that cycle.
  - Both ctrl lines high: multiply wins.
- Signed mode: magnitudes are taken at capture; result signs are fixed at the end.
  - Product sign = signA ^ signB.
  - Quotient sign = signA ^ signB.
  - Remainder sign = sign of dividend.
- RUN: one iteration per cycle, WIDTH iterations; after the WIDTH-th iteration go to DONE.
- DONE: outputs registered; data_resultRDY = 1 for exactly one cycle; then IDLE (or RUN on a new start).
- Latency: start sampled at edge t; data_resultRDY high during cycle t+WIDTH+1. Latency is fixed for every operand value, including exceptions.
- data_result, data_result_hi and data_exception update only on entry to DONE and hold until the next DONE or reset.
- data_busy = 1 in RUN, 0 in IDLE and DONE.
- Multiply: full 2*WIDTH product.
  - Low half goes to data_result; high half goes to data_result_hi.
  - Unsigned exception = (hi != 0).
  - Signed exception = (hi is not the sign extension of data_result[WIDTH-1]).
- Divide by zero: data_result = 0, data_result_hi = 0, exception = 1, regardless of signed/rem mode.
- Signed divide of MIN by -1: quotient = MIN, remainder = 0, exception = 1.
- All other divides: exception = 0.
- Remainder magnitude is always < |divisor|; quotient truncates toward zero.

Decomposition:
- Shared package multdiv_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - the op encoding (OP_MUL, OP_DIV);
  - helper constants for the signed MIN value of WIDTH.
- One sub-module, multdiv_step: combinational single iteration.
  - Shift-add for multiply; trial subtract / restore for divide.
  - Parametrised on WIDTH; instanced once.
  - The top holds the FSM, counter, capture registers, sign fix-up and exception logic.

Test Plan (WIDTH=32):
- Signed MULT 7 x -3 -> RDY at t+33; result 0xFFFFFFEB; hi 0xFFFFFFFF; exception 0; busy high cycles t+1..t+32.
- Unsigned MULT 0x00010000 x 0x00010000 -> result 0; hi 0x00000001; exception 1.
- Signed DIV -7 / 2:
  - REM=0 -> result 0xFFFFFFFD (-3), exception 0.
  - REM=1 -> 0xFFFFFFFF (-1).
- DIV 5 / 0 -> result 0, exception 1, RDY still at t+33.
- Signed DIV 0x80000000 / 0xFFFFFFFF -> result 0x80000000, exception 1.
- Abort and reset mid-operation:
  - Start MULT 3 x 4, then at t+10 start DIV 100 / 7 -> single RDY at t+10+33 with result 14; no pulse for the multiply.
  - Separately, assert reset at t+5 -> no RDY pulse; all outputs 0 next cycle.
